// File: rtl/sid_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sid_pkg : shared bus widths, command word layout and sequencer FSM encodings
// Revision: 1.0
// ----------------------------------------------------------------------------
package sid_pkg;

  localparam int SID_ADDR_W = 5;
  localparam int SID_DATA_W = 8;

  // Command word is {DELAY, ADDR, DATA} with DATA in the least significant bits
  localparam int CMD_DATA_LSB  = 0;
  localparam int CMD_ADDR_LSB  = CMD_DATA_LSB + SID_DATA_W;
  localparam int CMD_DELAY_LSB = CMD_ADDR_LSB + SID_ADDR_W;
  localparam int CMD_FIXED_W   = SID_ADDR_W + SID_DATA_W;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_WAIT  = 2'd1,
    SEQ_ISSUE = 2'd2
  } seq_state_t;

  function automatic int cmd_width(input int delay_w);
    return delay_w + CMD_FIXED_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sid_cmd_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sid_cmd_fifo : synchronous first-word-fall-through FIFO for sequencer commands
// Revision: 1.0
// ----------------------------------------------------------------------------
module sid_cmd_fifo
  import sid_pkg::*;
#(
  parameter int WIDTH = 29,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int            c_ptr_w     = $clog2(DEPTH);
  localparam logic [c_ptr_w:0] c_depth_cnt = (c_ptr_w + 1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == c_depth_cnt);
  assign o_empty   = (r_count == '0);
  // A push is refused whenever full, even if a pop frees a slot this cycle
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sid_write_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sid_write_sequencer : timed SID register write initiator; optional counters
// under SID_WRITE_SEQ_STATS_EN
// Revision: 1.0
// ----------------------------------------------------------------------------
module sid_write_sequencer
  import sid_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DELAY_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLKen,
  input  logic                  ENABLE,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DELAY_W-1:0]    IN_DELAY,
  input  logic [SID_ADDR_W-1:0] IN_ADDR,
  input  logic [SID_DATA_W-1:0] IN_DATA,
  output logic                  WR,
  output logic [SID_ADDR_W-1:0] ADDR,
  output logic [SID_DATA_W-1:0] DATA,
  output logic                  BUSY
`ifdef SID_WRITE_SEQ_STATS_EN
  ,
  output logic [15:0]           WR_COUNT,
  output logic                  UNDERRUN
`endif
);

  localparam int c_cmd_w = cmd_width(DELAY_W);

  logic [c_cmd_w-1:0]    w_cmd_in;
  logic [c_cmd_w-1:0]    w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic [DELAY_W-1:0]    w_head_delay;
  logic [SID_ADDR_W-1:0] w_head_addr;
  logic [SID_DATA_W-1:0] w_head_data;

  seq_state_t            r_state;
  seq_state_t            w_state_nxt;
  logic [DELAY_W-1:0]    r_cnt;
  logic [DELAY_W-1:0]    w_cnt_nxt;
  logic [SID_ADDR_W-1:0] r_h_addr;
  logic [SID_ADDR_W-1:0] w_h_addr_nxt;
  logic [SID_DATA_W-1:0] r_h_data;
  logic [SID_DATA_W-1:0] w_h_data_nxt;
  logic [SID_ADDR_W-1:0] r_addr;
  logic [SID_ADDR_W-1:0] w_addr_nxt;
  logic [SID_DATA_W-1:0] r_data;
  logic [SID_DATA_W-1:0] w_data_nxt;

  assign w_cmd_in     = {IN_DELAY, IN_ADDR, IN_DATA};
  assign w_head_delay = w_head[CMD_DELAY_LSB +: DELAY_W];
  assign w_head_addr  = w_head[CMD_ADDR_LSB +: SID_ADDR_W];
  assign w_head_data  = w_head[CMD_DATA_LSB +: SID_DATA_W];

  sid_cmd_fifo #(
    .WIDTH (c_cmd_w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .i_push  (IN_VALID),
    .i_pop   (w_pop),
    .i_din   (w_cmd_in),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign IN_READY = !w_full;
  assign BUSY     = !w_empty || (r_state != SEQ_IDLE);
  assign WR       = (r_state == SEQ_ISSUE);
  assign ADDR     = r_addr;
  assign DATA     = r_data;

  // The bus registers load only on entry to ISSUE so they keep the last write
  // while the next command is waiting out its delay.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_h_addr_nxt = r_h_addr;
    w_h_data_nxt = r_h_data;
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_pop        = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        if (ENABLE && !w_empty) begin
          w_pop        = 1'b1;
          w_h_addr_nxt = w_head_addr;
          w_h_data_nxt = w_head_data;
          if (w_head_delay == '0) begin
            w_state_nxt = SEQ_ISSUE;
            w_cnt_nxt   = '0;
            w_addr_nxt  = w_head_addr;
            w_data_nxt  = w_head_data;
          end else begin
            w_state_nxt = SEQ_WAIT;
            w_cnt_nxt   = w_head_delay;
          end
        end
      end
      SEQ_WAIT: begin
        if (CLKen && ENABLE) begin
          // Treating zero like one keeps the counter from ever wrapping
          if (r_cnt <= DELAY_W'(1)) begin
            w_state_nxt = SEQ_ISSUE;
            w_cnt_nxt   = '0;
            w_addr_nxt  = r_h_addr;
            w_data_nxt  = r_h_data;
          end else begin
            w_cnt_nxt = r_cnt - DELAY_W'(1);
          end
        end
      end
      SEQ_ISSUE: begin
        w_state_nxt = SEQ_IDLE;
      end
      default: begin
        w_state_nxt = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= SEQ_IDLE;
      r_cnt    <= '0;
      r_h_addr <= '0;
      r_h_data <= '0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_h_addr <= w_h_addr_nxt;
      r_h_data <= w_h_data_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
    end
  end

`ifdef SID_WRITE_SEQ_STATS_EN
  logic [15:0] r_wr_count;
  logic        r_wr_seen;
  logic        r_underrun;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_count <= '0;
      r_wr_seen  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (r_state == SEQ_ISSUE) begin
        r_wr_count <= r_wr_count + 16'd1;
        r_wr_seen  <= 1'b1;
      end
      if ((r_state == SEQ_IDLE) && ENABLE && w_empty && r_wr_seen) begin
        r_underrun <= 1'b1;
      end
    end
  end

  assign WR_COUNT = r_wr_count;
  assign UNDERRUN = r_underrun;
`endif

endmodule
`default_nettype wire
